fifo_flagged: RTL and testbench

Parametrised synchronous FIFO, the successor to the team's basic push/pop FIFO. It adds:
- empty, occupancy count and programmable almost-full/almost-empty flags
- sticky overflow/underflow error flags
- arbitrary (non power-of-2) depth
- selectable standard (registered read) or first-word-fall-through (FWFT) read mode

It sits between producer/consumer stages in the datapath as a general buffering element.

---
 rtl/fifo_flagged_if.sv | 34 +++
 rtl/fifo_flagged.sv | 98 +++++++++
 tb/tb_fifo_flagged.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_flagged_if.sv
// Handshake/status bundle between a producer/consumer pair and fifo_flagged.
// slave is the FIFO side, master is the side that pushes/pops.
interface fifo_flagged_if #(
    parameter int DATA_W    = 10,
    parameter int FIFO_SIZE = 6
);
    localparam int CNT_W = $clog2(FIFO_SIZE + 1);

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] data_in;
    logic              clr_err;
    logic [DATA_W-1:0] read_data;
    logic              valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport slave (
        input  push, pop, data_in, clr_err,
        output read_data, valid, full, empty, almost_full, almost_empty,
        output count, overflow, underflow
    );

    modport master (
        output push, pop, data_in, clr_err,
        input  read_data, valid, full, empty, almost_full, almost_empty,
        input  count, overflow, underflow
    );
endinterface

// File: rtl/fifo_flagged.sv
// Synchronous FIFO of arbitrary depth with occupancy flags, sticky error flags
// and a choice of registered-read or first-word-fall-through output.
module fifo_flagged #(
    parameter int DATA_W    = 10,
    parameter int FIFO_SIZE = 6,
    parameter int FWFT      = 0,
    parameter int AF_LEVEL  = FIFO_SIZE - 1,
    parameter int AE_LEVEL  = 1
) (
    input  logic          clock,
    input  logic          rst,
    fifo_flagged_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_SIZE + 1);
    localparam int PTR_W = $clog2(FIFO_SIZE);

    logic [DATA_W-1:0] mem_q [FIFO_SIZE];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              vld_q, vld_d;
    logic              empty, full;
    logic              pop_ok, push_ok;

    // Pointers wrap explicitly so any depth works, not just powers of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_SIZE - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(FIFO_SIZE));
    assign pop_ok  = bus.pop & ~empty;
    assign push_ok = bus.push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A new error in the same cycle as clr_err wins.
        ovf_d   = (ovf_q & ~bus.clr_err) | (bus.push & ~push_ok);
        unf_d   = (unf_q & ~bus.clr_err) | (bus.pop & ~pop_ok);
        vld_d   = pop_ok;
        rdata_d = pop_ok ? mem_q[rd_ptr_q] : rdata_q;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rdata_q  <= '0;
            vld_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            rdata_q  <= rdata_d;
            vld_q    <= vld_d;
        end
    end

    // Storage is never cleared; reset only discards it via the pointers.
    always_ff @(posedge clock) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.read_data = mem_q[rd_ptr_q];
            assign bus.valid     = ~empty;
        end else begin : g_std
            assign bus.read_data = rdata_q;
            assign bus.valid     = vld_q;
        end
    endgenerate

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_fifo_flagged.sv
// Drives a standard-mode and an FWFT-mode fifo_flagged with identical stimulus
// and checks both against a queue-based reference model and read scoreboards.
module tb_fifo_flagged;
    localparam int DW = 10;
    localparam int N  = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_flagged_if #(.DATA_W(DW), .FIFO_SIZE(N)) bus0 ();
    fifo_flagged_if #(.DATA_W(DW), .FIFO_SIZE(N)) bus1 ();

    fifo_flagged #(.DATA_W(DW), .FIFO_SIZE(N), .FWFT(0), .AF_LEVEL(5), .AE_LEVEL(1))
        dut0 (.clock(clk), .rst(rst), .bus(bus0));
    fifo_flagged #(.DATA_W(DW), .FIFO_SIZE(N), .FWFT(1), .AF_LEVEL(5), .AE_LEVEL(1))
        dut1 (.clock(clk), .rst(rst), .bus(bus1));

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] std_sb[$];
    logic [DW-1:0] fwft_sb[$];
    bit            m_ovf, m_unf, m_vld;
    logic [DW-1:0] m_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, then wait past the edge.
    task automatic step(input bit r, input bit p, input bit o, input bit c, input logic [DW-1:0] d);
        bit pop_ok, push_ok;
        logic [DW-1:0] w;
        rst = r;
        bus0.push = p;  bus1.push = p;
        bus0.pop = o;   bus1.pop = o;
        bus0.clr_err = c; bus1.clr_err = c;
        bus0.data_in = d; bus1.data_in = d;
        if (r) begin
            mq.delete();
            m_ovf = 0; m_unf = 0; m_vld = 0; m_rd = '0;
            mon_en = 1'b1;
        end else begin
            pop_ok  = o && (mq.size() != 0);
            push_ok = p && ((mq.size() < N) || pop_ok);
            m_vld = pop_ok;
            if (pop_ok) begin
                w = mq.pop_front();
                m_rd = w;
                std_sb.push_back(w);
                fwft_sb.push_back(w);
            end
            if (push_ok) mq.push_back(d);
            m_ovf = (m_ovf && !c) || (p && !push_ok);
            m_unf = (m_unf && !c) || (o && !pop_ok);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, '0);
    endtask

    // State/flag monitor, sampled 1 time unit after each rising edge.
    always begin
        int sz;
        logic [DW-1:0] w;
        @(posedge clk);
        #1;
        if (mon_en) begin
            sz = mq.size();
            chk("count_std", bus0.count, sz);
            chk("count_fwft", bus1.count, sz);
            chk("empty", bus0.empty, sz == 0);
            chk("full", bus0.full, sz == N);
            chk("almost_full", bus0.almost_full, sz >= 5);
            chk("almost_empty", bus0.almost_empty, sz <= 1);
            chk("overflow_std", bus0.overflow, m_ovf);
            chk("underflow_std", bus0.underflow, m_unf);
            chk("overflow_fwft", bus1.overflow, m_ovf);
            chk("underflow_fwft", bus1.underflow, m_unf);
            chk("valid_std", bus0.valid, m_vld);
            chk("rdata_std", bus0.read_data, m_rd);
            if (bus0.valid === 1'b1) begin
                if (std_sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_std: got word %0d required none", bus0.read_data);
                end else begin
                    w = std_sb.pop_front();
                    chk("sb_std", bus0.read_data, w);
                end
            end
            chk("valid_fwft", bus1.valid, sz != 0);
            if (sz != 0) chk("head_fwft", bus1.read_data, mq[0]);
        end
    end

    // FWFT consumption monitor: the word under an accepted pop is mid-cycle read_data.
    always begin
        logic [DW-1:0] w;
        @(negedge clk);
        if (mon_en && rst === 1'b0 && bus1.pop === 1'b1 && bus1.valid === 1'b1) begin
            if (fwft_sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_fwft: got word %0d required none", bus1.read_data);
            end else begin
                w = fwft_sb.pop_front();
                chk("sb_fwft", bus1.read_data, w);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pp, po;
        bus0.push = 0; bus0.pop = 0; bus0.clr_err = 0; bus0.data_in = '0;
        bus1.push = 0; bus1.pop = 0; bus1.clr_err = 0; bus1.data_in = '0;
        rst = 1'b1;

        // Reset / idle
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_count", bus0.count, 0);
        chk("rst_empty", bus0.empty, 1);
        chk("rst_ae", bus0.almost_empty, 1);
        chk("rst_full", bus0.full, 0);
        chk("rst_af", bus0.almost_full, 0);
        chk("rst_rdata", bus0.read_data, 0);
        chk("rst_valid", bus0.valid, 0);
        chk("rst_ovf", bus0.overflow, 0);
        chk("rst_unf", bus0.underflow, 0);

        // Basic order
        step(0, 1, 0, 0, 101);
        step(0, 1, 0, 0, 202);
        step(0, 1, 0, 0, 303);
        chk("t2_count", bus0.count, 3);
        step(0, 0, 1, 0, 0); chk("t2_rd0", bus0.read_data, 101); chk("t2_v0", bus0.valid, 1);
        step(0, 0, 1, 0, 0); chk("t2_rd1", bus0.read_data, 202);
        step(0, 0, 1, 0, 0); chk("t2_rd2", bus0.read_data, 303);
        step(0, 0, 1, 0, 0);
        chk("t2_unf", bus0.underflow, 1);
        chk("t2_hold", bus0.read_data, 303);
        chk("t2_v3", bus0.valid, 0);
        step(0, 0, 0, 1, 0);

        // Full / overflow
        for (int i = 1; i <= 6; i++) begin
            step(0, 1, 0, 0, DW'(11 * i));
            chk("t3_af", bus0.almost_full, i >= 5);
            chk("t3_full", bus0.full, i == 6);
        end
        step(0, 1, 0, 0, 77);
        chk("t3_ovf", bus0.overflow, 1);
        chk("t3_count", bus0.count, 6);
        for (int i = 1; i <= 6; i++) begin
            step(0, 0, 1, 0, 0);
            chk("t3_rd", bus0.read_data, 11 * i);
        end
        step(0, 0, 0, 1, 0);
        chk("t3_clr", bus0.overflow, 0);

        // Full with push+pop, pointer wrap
        for (int i = 1; i <= 6; i++) step(0, 1, 0, 0, DW'(i));
        step(0, 1, 1, 0, 99);
        chk("t4_count", bus0.count, 6);
        chk("t4_rd", bus0.read_data, 1);
        chk("t4_ovf", bus0.overflow, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, 0, 0);
            chk("t4_drain", bus0.read_data, (i < 5) ? i + 2 : 99);
        end

        // FWFT behaviour
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 5);
        chk("t5_v", bus1.valid, 1);
        chk("t5_rd", bus1.read_data, 5);
        step(0, 1, 0, 0, 7);
        chk("t5_head", bus1.read_data, 5);
        step(0, 0, 1, 0, 0);
        chk("t5_next", bus1.read_data, 7);
        step(0, 0, 1, 0, 0);
        chk("t5_v0", bus1.valid, 0);
        chk("t5_empty", bus1.empty, 1);
        step(0, 1, 1, 0, 9);
        chk("t5_unf", bus1.underflow, 1);
        chk("t5_count", bus1.count, 1);

        // Reset mid-operation and clr_err vs new error
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, DW'(40 + i));
        chk("t6_pre", bus0.count, 4);
        step(1, 0, 0, 0, 0);
        chk("t6_count", bus0.count, 0);
        chk("t6_empty", bus0.empty, 1);
        chk("t6_unf0", bus0.underflow, 0);
        step(0, 0, 1, 0, 0);
        chk("t6_unf1", bus0.underflow, 1);
        step(0, 0, 1, 1, 0);
        chk("t6_unf_clr", bus0.underflow, 1);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, DW'(i));
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0);
        chk("t6_ovf_clr", bus0.overflow, 1);
        step(1, 0, 0, 0, 0);

        // Randomised phase with fill/drain bias
        for (int i = 0; i < 3000; i++) begin
            case ((i / 150) % 3)
                0:       begin pp = 80; po = 30; end
                1:       begin pp = 30; po = 80; end
                default: begin pp = 50; po = 50; end
            endcase
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < pp,
                 $urandom_range(0, 99) < po,
                 $urandom_range(0, 15) == 0,
                 DW'($urandom));
        end

        idle();
        idle();
        chk("sb_std_left", std_sb.size(), 0);
        chk("sb_fwft_left", fwft_sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
